// File: rtl/tpx3_ext_sync_rx.sv
// rtl/tpx3_ext_sync_rx.sv - client receiver turning external T0/reset sync lines into clean CLK40 pulses
//
// Purpose:
//   Synchronises and glitch-filters the asynchronous T0_SYNC_EXT and RESET_EXT lines, turns
//   each filtered rising edge into a fixed-width pulse, then applies a holdoff dead time.
//   A reset event outranks a T0 event and can cut a running T0 pulse short.
//
// Ports:
//   CLK40        in   chip clock, the only clock
//   RST          in   synchronous active-high reset
//   ENABLE       in   0 forces the FSM to idle and ignores events
//   CLR_STATUS   in   one-cycle strobe clearing CONFLICT and both counters
//   T0_SYNC_EXT  in   asynchronous T0 line
//   RESET_EXT    in   asynchronous reset line
//   T0_SYNC_OUT  out  T0 pulse, PULSE_LEN cycles
//   RESET_OUT    out  reset pulse, PULSE_LEN cycles
//   BUSY         out  FSM not idle
//   CONFLICT     out  sticky: an event was dropped or a pulse aborted
//   T0_CNT       out  accepted T0 events, wrapping
//   RST_CNT      out  accepted reset events, wrapping
module tpx3_ext_sync_rx #(
  parameter int FILTER_LEN = 4,
  parameter int PULSE_LEN  = 8,
  parameter int HOLDOFF    = 256,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 CLK40,
  input  logic                 RST,
  input  logic                 ENABLE,
  input  logic                 CLR_STATUS,
  input  logic                 T0_SYNC_EXT,
  input  logic                 RESET_EXT,
  output logic                 T0_SYNC_OUT,
  output logic                 RESET_OUT,
  output logic                 BUSY,
  output logic                 CONFLICT,
  output logic [CNT_WIDTH-1:0] T0_CNT,
  output logic [CNT_WIDTH-1:0] RST_CNT
);

  localparam int FW          = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int CMAX        = (PULSE_LEN > HOLDOFF) ? PULSE_LEN : HOLDOFF;
  localparam int CCW         = $clog2(CMAX + 1);
  localparam int HOLD_LAST_I = (HOLDOFF > 0) ? HOLDOFF - 1 : 0;

  localparam logic [FW-1:0]  FILT_LAST  = FW'(FILTER_LEN - 1);
  localparam logic [CCW-1:0] PULSE_LAST = CCW'(PULSE_LEN - 1);
  localparam logic [CCW-1:0] HOLD_LAST  = CCW'(HOLD_LAST_I);

  typedef enum logic [1:0] {S_IDLE, S_T0, S_RST, S_HOLD} state_t;

  // Channel 0 is T0, channel 1 is reset.
  logic [1:0]    line_raw;
  logic [1:0]    sync1;
  logic [1:0]    sync2;
  logic [1:0]    level;
  logic [1:0]    level_d;
  logic [1:0]    evt;
  logic [FW-1:0] filt_cnt [2];

  state_t         state;
  state_t         state_n;
  logic [CCW-1:0] cyc;
  logic [CCW-1:0] cyc_n;
  logic           t0_inc;
  logic           rst_inc;
  logic           drop;

  assign line_raw = {RESET_EXT, T0_SYNC_EXT};
  assign evt      = level & ~level_d;

  // Front end runs independently of ENABLE so that enabling with a line already high
  // does not fabricate an event.
  always_ff @(posedge CLK40) begin
    if (RST) begin
      sync1   <= '0;
      sync2   <= '0;
      level   <= '0;
      level_d <= '0;
      for (int i = 0; i < 2; i++) filt_cnt[i] <= '0;
    end else begin
      sync1   <= line_raw;
      sync2   <= sync1;
      level_d <= level;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == level[i]) begin
          filt_cnt[i] <= '0;
        end else if (filt_cnt[i] == FILT_LAST) begin
          // FILTER_LEN-th consecutive disagreeing sample flips the level.
          level[i]    <= ~level[i];
          filt_cnt[i] <= '0;
        end else begin
          filt_cnt[i] <= filt_cnt[i] + FW'(1);
        end
      end
    end
  end

  always_ff @(posedge CLK40) begin
    if (RST) begin
      state <= S_IDLE;
      cyc   <= '0;
    end else begin
      state <= state_n;
      cyc   <= cyc_n;
    end
  end

  always_comb begin
    state_n = state;
    cyc_n   = cyc;
    t0_inc  = 1'b0;
    rst_inc = 1'b0;
    drop    = 1'b0;
    if (!ENABLE) begin
      state_n = S_IDLE;
      cyc_n   = '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (evt[1]) begin
            state_n = S_RST;
            cyc_n   = '0;
            rst_inc = 1'b1;
            drop    = evt[0];
          end else if (evt[0]) begin
            state_n = S_T0;
            cyc_n   = '0;
            t0_inc  = 1'b1;
          end
        end
        S_T0: begin
          if (evt[1]) begin
            // Reset pre-empts the T0 pulse and restarts the width counter.
            state_n = S_RST;
            cyc_n   = '0;
            rst_inc = 1'b1;
            drop    = 1'b1;
          end else begin
            drop = evt[0];
            if (cyc == PULSE_LAST) begin
              state_n = (HOLDOFF == 0) ? S_IDLE : S_HOLD;
              cyc_n   = '0;
            end else begin
              cyc_n = cyc + CCW'(1);
            end
          end
        end
        S_RST: begin
          drop = |evt;
          if (cyc == PULSE_LAST) begin
            state_n = (HOLDOFF == 0) ? S_IDLE : S_HOLD;
            cyc_n   = '0;
          end else begin
            cyc_n = cyc + CCW'(1);
          end
        end
        S_HOLD: begin
          // Events on the exit cycle are still dropped; idle listens from the next cycle.
          drop = |evt;
          if (cyc == HOLD_LAST) begin
            state_n = S_IDLE;
            cyc_n   = '0;
          end else begin
            cyc_n = cyc + CCW'(1);
          end
        end
        default: begin
          state_n = S_IDLE;
          cyc_n   = '0;
        end
      endcase
    end
  end

  // Outputs are registered from the next state so they line up with the state register.
  always_ff @(posedge CLK40) begin
    if (RST) begin
      T0_SYNC_OUT <= 1'b0;
      RESET_OUT   <= 1'b0;
      BUSY        <= 1'b0;
      CONFLICT    <= 1'b0;
      T0_CNT      <= '0;
      RST_CNT     <= '0;
    end else begin
      T0_SYNC_OUT <= (state_n == S_T0);
      RESET_OUT   <= (state_n == S_RST);
      BUSY        <= (state_n != S_IDLE);
      if (CLR_STATUS) begin
        CONFLICT <= 1'b0;
        T0_CNT   <= '0;
        RST_CNT  <= '0;
      end else begin
        if (drop)    CONFLICT <= 1'b1;
        if (t0_inc)  T0_CNT   <= T0_CNT + CNT_WIDTH'(1);
        if (rst_inc) RST_CNT  <= RST_CNT + CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_tpx3_ext_sync_rx.sv
// tb/tb_tpx3_ext_sync_rx.sv - self-checking bench for tpx3_ext_sync_rx
module tb_tpx3_ext_sync_rx;

  localparam int F  = 4;
  localparam int P  = 8;
  localparam int H  = 256;
  localparam int CW = 4;

  localparam int M_IDLE = 0;
  localparam int M_T0   = 1;
  localparam int M_RST  = 2;
  localparam int M_HOLD = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          enable = 1'b1;
  logic          clr = 1'b0;
  logic          t0_ext = 1'b0;
  logic          rs_ext = 1'b0;
  logic          t0_out;
  logic          rs_out;
  logic          busy;
  logic          conflict;
  logic [CW-1:0] t0_cnt;
  logic [CW-1:0] rs_cnt;

  always #5 clk = ~clk;

  tpx3_ext_sync_rx #(
    .FILTER_LEN(F), .PULSE_LEN(P), .HOLDOFF(H), .CNT_WIDTH(CW)
  ) dut (
    .CLK40(clk), .RST(rst), .ENABLE(enable), .CLR_STATUS(clr),
    .T0_SYNC_EXT(t0_ext), .RESET_EXT(rs_ext),
    .T0_SYNC_OUT(t0_out), .RESET_OUT(rs_out), .BUSY(busy), .CONFLICT(conflict),
    .T0_CNT(t0_cnt), .RST_CNT(rs_cnt)
  );

  // Reference model: a line's level flips once the last F samples seen through the
  // two-stage synchroniser all disagree with it; the pulse FSM is tracked by deadlines.
  bit [F+1:0] m_hist [2];
  bit [1:0]   m_lvl;
  bit [1:0]   m_pend;
  int         m_mode;
  int         m_until;
  int         m_cyc;
  bit         m_conf;
  bit [CW-1:0] m_t0c;
  bit [CW-1:0] m_rsc;
  bit         m_started;

  function automatic bit window_flips(bit [F+1:0] h, bit lvl);
    bit [F-1:0] win;
    win = h[F+1:2];
    return lvl ? (win == '0) : (win == '1);
  endfunction

  always @(posedge clk) begin
    bit et;
    bit er;
    bit [1:0] raw;
    m_cyc++;
    if (rst) begin
      m_hist[0] = '0;
      m_hist[1] = '0;
      m_lvl     = '0;
      m_pend    = '0;
      m_mode    = M_IDLE;
      m_conf    = 1'b0;
      m_t0c     = '0;
      m_rsc     = '0;
      m_started = 1'b1;
    end else begin
      et = m_pend[0];
      er = m_pend[1];
      if (!enable) begin
        m_mode = M_IDLE;
      end else if (m_mode == M_IDLE) begin
        if (er) begin
          m_mode = M_RST; m_until = m_cyc + P - 1; m_rsc++;
          if (et) m_conf = 1'b1;
        end else if (et) begin
          m_mode = M_T0; m_until = m_cyc + P - 1; m_t0c++;
        end
      end else if (m_mode == M_T0 && er) begin
        m_mode = M_RST; m_until = m_cyc + P - 1; m_rsc++; m_conf = 1'b1;
      end else if (m_mode == M_T0 || m_mode == M_RST) begin
        if (et || er) m_conf = 1'b1;
        if (m_cyc > m_until) begin
          if (H == 0) m_mode = M_IDLE;
          else begin m_mode = M_HOLD; m_until = m_cyc + H - 1; end
        end
      end else begin
        if (et || er) m_conf = 1'b1;
        if (m_cyc > m_until) m_mode = M_IDLE;
      end
      if (clr) begin
        m_conf = 1'b0; m_t0c = '0; m_rsc = '0;
      end
      raw = {rs_ext, t0_ext};
      for (int c = 0; c < 2; c++) begin
        m_hist[c] = {m_hist[c][F:0], raw[c]};
        if (window_flips(m_hist[c], m_lvl[c])) begin
          m_lvl[c]  = ~m_lvl[c];
          m_pend[c] = m_lvl[c];
        end else begin
          m_pend[c] = 1'b0;
        end
      end
    end
  end

  int nerr = 0;
  int nchk = 0;
  int o_i, first_t0, w_t0, w_rs, last_busy;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic begin_obs();
    o_i = 0; first_t0 = -1; w_t0 = 0; w_rs = 0; last_busy = -1;
  endtask

  task automatic step();
    logic e_t0, e_rs, e_busy;
    @(negedge clk);
    if (m_started) begin
      e_t0   = (m_mode == M_T0);
      e_rs   = (m_mode == M_RST);
      e_busy = (m_mode != M_IDLE);
      nchk++;
      if (t0_out !== e_t0 || rs_out !== e_rs || busy !== e_busy || conflict !== m_conf ||
          t0_cnt !== m_t0c || rs_cnt !== m_rsc) begin
        nerr++;
        $display("FAIL model_cmp edge %0d: got t0=%b rst=%b busy=%b conf=%b t0cnt=%0d rstcnt=%0d want t0=%b rst=%b busy=%b conf=%b t0cnt=%0d rstcnt=%0d",
                 m_cyc, t0_out, rs_out, busy, conflict, t0_cnt, rs_cnt,
                 e_t0, e_rs, e_busy, m_conf, m_t0c, m_rsc);
      end
    end
    if (t0_out === 1'b1) begin
      if (first_t0 < 0) first_t0 = o_i;
      w_t0++;
    end
    if (rs_out === 1'b1) w_rs++;
    if (busy === 1'b1) last_busy = o_i;
    o_i++;
  endtask

  task automatic clear_status();
    clr = 1'b1;
    step();
    clr = 1'b0;
    step();
  endtask

  logic [CW-1:0] mid_cnt;
  logic          mid_conf;
  logic          out_at7, out_at8, busy_at8;
  logic [31:0]   rst_snap;

  initial begin
    begin_obs();
    repeat (3) step();
    check("reset_state", {t0_out, rs_out, busy, conflict, t0_cnt, rs_cnt}, 0);
    check("model_reset_cnt", {m_t0c, m_rsc}, 0);
    rst = 1'b0;
    step();

    // single T0 edge
    t0_ext = 1'b1;
    begin_obs();
    for (int i = 0; i < 300; i++) begin
      step();
      if (i == 20) t0_ext = 1'b0;
    end
    check("t1_first_high", first_t0, 6);
    check("t1_width", w_t0, 8);
    check("t1_t0_cnt", t0_cnt, 1);
    check("t1_model_t0_cnt", m_t0c, 1);
    check("t1_last_busy", last_busy, 269);
    check("t1_conflict", conflict, 0);

    // 3-cycle glitch is filtered
    clear_status();
    rs_ext = 1'b1;
    begin_obs();
    for (int i = 0; i < 40; i++) begin
      step();
      if (i == 2) rs_ext = 1'b0;
    end
    check("t2_rst_width", w_rs, 0);
    check("t2_rst_cnt", rs_cnt, 0);
    check("t2_conflict", conflict, 0);

    // 4-cycle pulse is just long enough
    rs_ext = 1'b1;
    begin_obs();
    for (int i = 0; i < 300; i++) begin
      step();
      if (i == 3) rs_ext = 1'b0;
    end
    check("t2b_rst_width", w_rs, 8);
    check("t2b_rst_cnt", rs_cnt, 1);

    // both lines together: reset wins
    clear_status();
    t0_ext = 1'b1;
    rs_ext = 1'b1;
    begin_obs();
    for (int i = 0; i < 300; i++) begin
      step();
      if (i == 20) begin t0_ext = 1'b0; rs_ext = 1'b0; end
    end
    check("t3_rst_width", w_rs, 8);
    check("t3_t0_width", w_t0, 0);
    check("t3_cnts", {t0_cnt, rs_cnt}, {4'd0, 4'd1});
    check("t3_conflict", conflict, 1);

    // reset three cycles after T0 truncates the T0 pulse
    clear_status();
    t0_ext = 1'b1;
    begin_obs();
    for (int i = 0; i < 300; i++) begin
      step();
      if (i == 2) rs_ext = 1'b1;
      if (i == 20) begin t0_ext = 1'b0; rs_ext = 1'b0; end
    end
    check("t4_t0_width", w_t0, 3);
    check("t4_rst_width", w_rs, 8);
    check("t4_cnts", {t0_cnt, rs_cnt}, {4'd1, 4'd1});
    check("t4_conflict", conflict, 1);

    // second edge in holdoff dropped, third accepted
    clear_status();
    t0_ext = 1'b1;
    begin_obs();
    for (int i = 0; i < 700; i++) begin
      step();
      if (i == 20 || i == 119 || i == 419) t0_ext = 1'b0;
      if (i == 99 || i == 399) t0_ext = 1'b1;
      if (i == 200) begin mid_cnt = t0_cnt; mid_conf = conflict; end
    end
    check("t5_mid_t0_cnt", mid_cnt, 1);
    check("t5_mid_conflict", mid_conf, 1);
    check("t5_end_t0_cnt", t0_cnt, 2);
    check("t5_t0_width", w_t0, 16);

    // ENABLE low mid-pulse
    clear_status();
    t0_ext = 1'b1;
    begin_obs();
    for (int i = 0; i < 40; i++) begin
      step();
      if (i == 7) begin out_at7 = t0_out; enable = 1'b0; end
      if (i == 8) begin out_at8 = t0_out; busy_at8 = busy; end
      if (i == 15) enable = 1'b1;
      if (i == 20) t0_ext = 1'b0;
    end
    check("t6_out_before_disable", out_at7, 1);
    check("t6_out_after_disable", {out_at8, busy_at8}, 0);
    check("t6_t0_cnt", t0_cnt, 1);

    // RST in the middle of a reset pulse
    rs_ext = 1'b1;
    begin_obs();
    for (int i = 0; i < 30; i++) begin
      step();
      if (i == 7) begin rst = 1'b1; rs_ext = 1'b0; end
      if (i == 9) begin
        rst_snap = {t0_out, rs_out, busy, conflict, t0_cnt, rs_cnt};
        rst = 1'b0;
      end
    end
    check("t6_rst_clears", rst_snap, 0);
    check("t6_rst_width", w_rs, 2);

    // CLR_STATUS on the increment cycle wins
    t0_ext = 1'b1;
    begin_obs();
    for (int i = 0; i < 300; i++) begin
      step();
      if (i == 5) clr = 1'b1;
      if (i == 6) clr = 1'b0;
      if (i == 20) t0_ext = 1'b0;
    end
    check("t7_clr_priority_cnt", t0_cnt, 0);
    check("t7_t0_width", w_t0, 8);

    // counter wrap
    for (int e = 0; e < 16; e++) begin
      t0_ext = 1'b1;
      for (int i = 0; i < 290; i++) begin
        step();
        if (i == 20) t0_ext = 1'b0;
      end
      if (e == 14) check("t8_cnt_full", t0_cnt, 15);
    end
    check("t8_cnt_wrapped", t0_cnt, 0);
    check("t8_conflict", conflict, 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
